// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, FSM states
// and default latencies.
package mdu_pkg;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } mduOp_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    MUL  = 2'b01,
    DIV  = 2'b10
  } mduState_t;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;

  function automatic logic isDiv(input mduOp_t op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath producing {hi,lo} and a divide-by-zero flag.
module mdu_arith
  import mdu_pkg::*;
(
  input  mduOp_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        divZero
);

  logic        [31:0] divisor;
  logic signed [63:0] prodS;
  logic        [63:0] prodU;
  logic signed [31:0] quotS;
  logic signed [31:0] remS;
  logic        [31:0] quotU;
  logic        [31:0] remU;

  // Substitute a divisor of 1 when b is zero so the dividers never see 0;
  // the caller discards the result anyway.
  assign divisor = (b == 32'd0) ? 32'd1 : b;

  assign prodS = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
  assign prodU = {32'd0, a} * {32'd0, b};
  assign quotS = $signed(a) / $signed(divisor);
  assign remS  = $signed(a) % $signed(divisor);
  assign quotU = a / divisor;
  assign remU  = a % divisor;

  always_comb begin
    result = 64'd0;
    case (op)
      OP_MULT:  result = prodS;
      OP_MULTU: result = prodU;
      OP_DIV:   result = {remS, quotS};
      OP_DIVU:  result = {remU, quotU};
      default:  result = 64'd0;
    endcase
  end

  assign divZero = isDiv(op) && (b == 32'd0);

endmodule

// File: rtl/mdu_ctrl.sv
// Multi-cycle HI/LO controller with pipeline stall generation.
// Optional MDU_CANCEL_EN adds a cancel input that aborts an operation in flight.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset_n,
`ifdef MDU_CANCEL_EN
  input  logic        cancel,
`endif
  input  logic        start_E,
  input  logic [1:0]  op_E,
  input  logic [31:0] a_E,
  input  logic [31:0] b_E,
  input  logic        mthi_E,
  input  logic        mtlo_E,
  input  logic [31:0] wdata_E,
  input  logic        md_useD,
  output logic        busy,
  output logic        stall_md,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

  mduState_t          state, stateNext;
  logic [CNT_W-1:0]   cnt, cntNext;
  logic [63:0]        pend, pendNext;
  logic               pendWrite, pendWriteNext;
  logic [31:0]        hiNext, loNext;
  logic [63:0]        arithResult;
  logic               divZero;
  logic               cancelReq;
  mduOp_t             opSel;

`ifdef MDU_CANCEL_EN
  assign cancelReq = cancel;
`else
  assign cancelReq = 1'b0;
`endif

  assign opSel = mduOp_t'(op_E);

  mdu_arith uArith (
    .op      (opSel),
    .a       (a_E),
    .b       (b_E),
    .result  (arithResult),
    .divZero (divZero)
  );

  assign busy     = (state != IDLE);
  assign stall_md = md_useD & (busy | start_E);

  always_comb begin
    stateNext     = state;
    cntNext       = cnt;
    pendNext      = pend;
    pendWriteNext = pendWrite;
    hiNext        = hi;
    loNext        = lo;
    case (state)
      IDLE: begin
        if (!cancelReq) begin
          if (start_E) begin
            pendNext      = arithResult;
            pendWriteNext = !divZero;
            if (isDiv(opSel)) begin
              stateNext = DIV;
              cntNext   = CNT_W'(DIV_CYCLES);
            end else begin
              stateNext = MUL;
              cntNext   = CNT_W'(MULT_CYCLES);
            end
          end else begin
            if (mthi_E) hiNext = wdata_E;
            if (mtlo_E) loNext = wdata_E;
          end
        end
      end
      MUL, DIV: begin
        // Requests arriving here are deliberately ignored; only cancel or expiry matter.
        if (cancelReq) begin
          stateNext     = IDLE;
          cntNext       = '0;
          pendWriteNext = 1'b0;
        end else if (cnt == CNT_W'(1)) begin
          if (pendWrite) {hiNext, loNext} = pend;
          stateNext = IDLE;
          cntNext   = '0;
        end else begin
          cntNext = cnt - CNT_W'(1);
        end
      end
      default: begin
        stateNext = IDLE;
        cntNext   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      pend      <= 64'd0;
      pendWrite <= 1'b0;
      hi        <= 32'd0;
      lo        <= 32'd0;
    end else begin
      state     <= stateNext;
      cnt       <= cntNext;
      pend      <= pendNext;
      pendWrite <= pendWriteNext;
      hi        <= hiNext;
      lo        <= loNext;
    end
  end

endmodule

// File: doc/mdu_ctrl.md
MDU_CTRL -- requirements
Module: mdu_ctrl

Interface
REQ-001 SHALL take parameter MULT_CYCLES, default 5: busy cycles for mult/multu.
REQ-002 SHALL take parameter DIV_CYCLES, default 10: busy cycles for div/divu.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port start_E, input, 1 bit: a mult/div instruction is in E this cycle.
REQ-006 SHALL have port op_E, input, 2 bits: operation select; 00 mult, 01 multu, 10 div, 11 divu.
REQ-007 SHALL have ports a_E and b_E, input, 32 bits each: rs and rt operand values, already forwarded.
REQ-008 SHALL have ports mthi_E and mtlo_E, input, 1 bit each: direct HI/LO write from wdata_E.
REQ-009 SHALL have port wdata_E, input, 32 bits: data for mthi/mtlo.
REQ-010 SHALL have port md_useD, input, 1 bit: instruction in D is mult/div/mfhi/mflo/mthi/mtlo.
REQ-011 SHALL have port busy, output, 1 bit: an operation is in progress.
REQ-012 SHALL have port stall_md, output, 1 bit: OR-ed by the pipeline into StallF/StallD/FlushE.
REQ-013 SHALL have ports hi and lo, output, 32 bits each: architectural HI/LO registers.

Function
REQ-014 SHALL implement FSM states IDLE, MUL and DIV; busy SHALL be 1 only in MUL or DIV.
REQ-015 In IDLE, start_E SHALL capture the result of op_E on a_E/b_E into a pending register and load the counter.
- mult/multu: counter = MULT_CYCLES, go to MUL.
- div/divu: counter = DIV_CYCLES, go to DIV.
REQ-016 In MUL/DIV, the counter SHALL decrement each cycle; at counter==1 the pending HI/LO SHALL be written and the FSM SHALL return to IDLE.
- Result: hi/lo updated and busy=0 exactly N cycles after the start edge.
REQ-017 Arithmetic:
- mult/multu: 64-bit signed/unsigned product, HI = bits [63:32], LO = bits [31:0].
- div/divu: LO = quotient, HI = remainder; signed variants truncate toward zero and the remainder takes the dividend's sign.
REQ-018 If b_E==0 on div/divu, the FSM SHALL still be busy DIV_CYCLES cycles, and HI/LO SHALL remain unchanged.
REQ-019 mthi_E/mtlo_E in IDLE SHALL write hi/lo on the next edge with zero busy cycles.
REQ-020 stall_md SHALL equal md_useD & (busy | start_E), combinationally.
REQ-021 start_E, mthi_E or mtlo_E asserted while busy SHALL be ignored, with no state change; a bench assertion SHALL flag it as a protocol error.
REQ-022 Simultaneous start_E and mthi_E/mtlo_E in IDLE SHALL give priority to start_E.

Reset
REQ-023 reset_n low SHALL immediately force state=IDLE, counter=0, pending=0, hi=0, lo=0, busy=0, regardless of any operation in progress.
REQ-024 While reset_n is low, stall_md SHALL still follow REQ-020 with busy=0.

Configuration
REQ-025 With macro MDU_CANCEL_EN defined, the module SHALL have an input port cancel, 1 bit.
- cancel in MUL/DIV: go to IDLE on the next edge, pending result discarded, hi/lo unchanged.
- cancel in IDLE: blocks any start_E/mthi_E/mtlo_E that cycle.
REQ-026 Without MDU_CANCEL_EN, the cancel port SHALL be absent and operations SHALL always run to completion.

Structure
REQ-027 Package mdu_pkg SHALL hold the op_E encodings, the FSM state enum and the default MULT_CYCLES/DIV_CYCLES constants.
REQ-028 Sub-module mdu_arith SHALL be purely combinational: op, a, b in; 64-bit {hi,lo} result and a div-by-zero flag out.
REQ-029 The counter width SHALL be $clog2(max(MULT_CYCLES, DIV_CYCLES)+1).

Verification
REQ-030 Test multu: start_E, op=01, a=0xFFFFFFFF, b=2.
- busy for 5 cycles.
- Then hi=0x00000001, lo=0xFFFFFFFE.
REQ-031 Test signed div: start_E, op=10, a=-7, b=2.
- busy for 10 cycles.
- Then lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 Test mfhi hazard: md_useD=1 on cycle 2 of a mult.
- stall_md=1 until busy falls.
- stall_md=0 the cycle after.
REQ-033 Test div-by-zero: hi=0x11, lo=0x22, then divu with b=0.
- busy for 10 cycles.
- hi/lo remain 0x11/0x22.
REQ-034 Test reset mid-op: reset_n pulsed low on cycle 3 of a div.
- busy=0, hi=lo=0 immediately.
- Next start_E behaves normally.
REQ-035 Test cancel (MDU_CANCEL_EN only): cancel on cycle 2 of a mult.
- busy=0 next cycle.
- hi/lo unchanged.
